// File: rtl/turn_timer_ctrl_if.sv
// Request/status bundle between the game FSM (master) and the turn timer (slave).
interface turn_timer_ctrl_if #(
  parameter int SEC_W = 4
);
  logic             start;
  logic             pause;
  logic             cancel;
  logic [SEC_W-1:0] limit;
  logic [SEC_W-1:0] seconds_left;
  logic             running;
  logic             paused;
  logic             expired;
  logic             warn;

  modport master (
    output start, pause, cancel, limit,
    input  seconds_left, running, paused, expired, warn
  );

  modport slave (
    input  start, pause, cancel, limit,
    output seconds_left, running, paused, expired, warn
  );
endinterface

// File: rtl/turn_timer_ctrl.sv
// Per-turn countdown: one-second prescaler, pause/resume, cancel, one-cycle expiry pulse.
// Optional low-time warning output is built only when TURN_TIMER_WARN_EN is defined.
//
// state     | meaning
// ST_IDLE   | no turn active, seconds_left = 0
// ST_RUN    | counting down, prescaler advancing
// ST_PAUSE  | countdown frozen, partial second held in prescaler
// ST_EXPIRE | single-cycle expiry pulse, then back to idle
module turn_timer_ctrl #(
  parameter int CLK_DIV  = 25_000_000,
  parameter int DIV_W    = 25,
  parameter int SEC_W    = 4,
  parameter int WARN_SEC = 3
) (
  input  logic                clk,
  input  logic                reset,
  turn_timer_ctrl_if.slave    tmr
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSE  = 2'd2,
    ST_EXPIRE = 2'd3
  } state_t;

  localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [SEC_W-1:0] SEC_ONE    = SEC_W'(1);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [SEC_W-1:0] sec_q,   sec_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      sec_q   <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      sec_q   <= sec_d;
    end
  end

  // Request priority is cancel > start > pause in every state.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    sec_d   = sec_q;
    case (state_q)
      ST_IDLE: begin
        if (tmr.cancel) begin
          sec_d   = '0;
          presc_d = '0;
        end else if (tmr.start) begin
          state_d = ST_RUN;
          sec_d   = tmr.limit;
          presc_d = '0;
        end
      end
      ST_RUN: begin
        if (tmr.cancel) begin
          state_d = ST_IDLE;
          sec_d   = '0;
          presc_d = '0;
        end else if (tmr.start) begin
          sec_d   = tmr.limit;
          presc_d = '0;
        end else if (sec_q == '0) begin
          // A zero limit expires right away instead of waiting a full second.
          state_d = ST_EXPIRE;
          presc_d = '0;
        end else if (tmr.pause) begin
          state_d = ST_PAUSE;
        end else if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          sec_d   = sec_q - SEC_ONE;
          if (sec_q == SEC_ONE) begin
            state_d = ST_EXPIRE;
          end
        end else begin
          presc_d = presc_q + DIV_W'(1);
        end
      end
      ST_PAUSE: begin
        if (tmr.cancel) begin
          state_d = ST_IDLE;
          sec_d   = '0;
          presc_d = '0;
        end else if (tmr.start) begin
          state_d = ST_RUN;
          sec_d   = tmr.limit;
          presc_d = '0;
        end else if (!tmr.pause) begin
          state_d = ST_RUN;
        end
      end
      ST_EXPIRE: begin
        state_d = ST_IDLE;
        sec_d   = '0;
        presc_d = '0;
        if (!tmr.cancel && tmr.start) begin
          state_d = ST_RUN;
          sec_d   = tmr.limit;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sec_d   = '0;
        presc_d = '0;
      end
    endcase
  end

  assign tmr.seconds_left = sec_q;
  assign tmr.running      = (state_q == ST_RUN);
  assign tmr.paused       = (state_q == ST_PAUSE);
  assign tmr.expired      = (state_q == ST_EXPIRE);

`ifdef TURN_TIMER_WARN_EN
  localparam logic [SEC_W-1:0] WARN_THR = SEC_W'(WARN_SEC);
  assign tmr.warn = ((state_q == ST_RUN) || (state_q == ST_PAUSE)) && (sec_q <= WARN_THR);
`else
  assign tmr.warn = 1'b0;
`endif

endmodule

// File: doc/turn_timer_ctrl.md
# turn_timer_ctrl

Countdown controller that sequences the game's one-second timebase for a per-turn time limit. Loads a limit in seconds, runs an internal prescaler producing one tick per second, supports pause/resume and cancel, and emits a single-cycle expiry pulse. Sits between the game FSM (start/pause/cancel requests) and the display/scoring logic (remaining seconds, expiry).

## Interface
- CLK_DIV, 25_000_000, clock cycles per second tick (≥2)
- DIV_W, 25, prescaler width; must hold CLK_DIV-1
- SEC_W, 4, width of limit and remaining-seconds count
- WARN_SEC, 3, warning threshold in seconds (used only with TURN_TIMER_WARN_EN)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse: load `limit`, begin counting
- pause  in  1  level: while high, counting freezes
- cancel  in  1  single-cycle pulse: abort, return to idle
- limit  in  SEC_W  turn length in seconds, sampled on `start`
- seconds_left  out  SEC_W  remaining whole seconds
- running  out  1  high in RUN
- paused  out  1  high in PAUSE
- expired  out  1  one-cycle pulse when countdown reaches 0
- warn  out  1  high while RUN/PAUSE and seconds_left ≤ WARN_SEC (feature-gated)

## Operation
- States: IDLE, RUN, PAUSE, EXPIRE.
- Request priority each cycle: cancel > start > pause.
- IDLE: start → RUN, seconds_left ← limit, prescaler ← 0. pause ignored.
- RUN: cancel → IDLE, seconds_left ← 0. start → restart (reload limit, prescaler ← 0, stay RUN). pause=1 → PAUSE. Otherwise prescaler increments; at CLK_DIV-1 it wraps to 0 and issues a tick.
- Tick in RUN: seconds_left ← seconds_left − 1; if result is 0 → EXPIRE.
- start with limit=0: enter RUN, then EXPIRE on the next cycle without waiting for a tick; seconds_left stays 0.
- PAUSE: prescaler and seconds_left hold (partial second preserved). pause=0 → RUN. cancel → IDLE. start → RUN with reload.
- EXPIRE: lasts exactly one cycle, expired=1, seconds_left=0, then → IDLE. start in this cycle is honoured (→ RUN, reload); cancel → IDLE.
- seconds_left never wraps below 0; decrements are unsigned, SEC_W bits.
- Outputs are registered; running/paused/expired decode directly from state.

## Timing
- Reset: state IDLE, prescaler 0, seconds_left 0, running 0, paused 0, expired 0, warn 0.
- start at cycle t → running=1 and seconds_left=limit at t+1.
- First tick occurs CLK_DIV cycles of RUN after start; seconds_left changes on the following edge. Total start-to-expired latency for limit=N: N·CLK_DIV+1 cycles, plus paused cycles.
- pause asserted in the cycle the prescaler is at CLK_DIV-1: pause wins, no tick; the tick fires in the first RUN cycle after resume.
- pause/cancel/start take effect at the next clock edge (one-cycle latency).
- Reset mid-countdown aborts immediately; no expired pulse.

## Configuration
- TURN_TIMER_WARN_EN defined: warn driven as specified (combinational from registered state and seconds_left); warn=0 in IDLE/EXPIRE.
- Undefined: warn tied to 0; comparator logic absent. Port list unchanged.

## Test plan
- CLK_DIV=4, limit=3, start, no pause → seconds_left 3,2,1,0 at 4-cycle spacing; expired high for exactly 1 cycle at cycle 13 after start; then IDLE.
- CLK_DIV=4, limit=2, pause held 10 cycles after 2 RUN cycles → seconds_left holds 2 throughout; first decrement 2 RUN cycles after release.
- limit=0, start → running for 1 cycle, expired next cycle, seconds_left=0.
- limit=5, cancel when seconds_left=3 → IDLE next cycle, seconds_left=0, no expired pulse; start+cancel same cycle → cancel wins.
- Restart: start with limit=4 while seconds_left=1 → seconds_left=4, prescaler restarted, no expired pulse.
- With TURN_TIMER_WARN_EN, WARN_SEC=3, limit=5 → warn rises when seconds_left=3, stays high during pause, falls on expiry; without macro warn constant 0.
